// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO I/O responder.
// Holds the register address map, the CTRL register bit positions,
// the register-select enum, the address decoder and the CTRL word packer.
package mmio_pkg;

  localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
  localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
  localparam logic [31:0] ADDR_TCNT  = 32'hF000_0020;
  localparam logic [31:0] ADDR_TLIM  = 32'hF000_0024;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;
  localparam logic [31:0] ADDR_TCTRL = 32'hF000_0120;

  localparam int READY_BIT = 0;
  localparam int OVR_BIT   = 2;

  // Status flag instance slots
  localparam int FLG_KEY   = 0;
  localparam int FLG_SW    = 1;
  localparam int FLG_TIM   = 2;
  localparam int NUM_FLAGS = 3;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_HEX,
    SEL_LEDR,
    SEL_KEY,
    SEL_SW,
    SEL_TCNT,
    SEL_TLIM,
    SEL_KCTRL,
    SEL_SCTRL,
    SEL_TCTRL
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e s;
    case (addr)
      ADDR_HEX:   s = SEL_HEX;
      ADDR_LEDR:  s = SEL_LEDR;
      ADDR_KEY:   s = SEL_KEY;
      ADDR_SW:    s = SEL_SW;
      ADDR_TCNT:  s = SEL_TCNT;
      ADDR_TLIM:  s = SEL_TLIM;
      ADDR_KCTRL: s = SEL_KCTRL;
      ADDR_SCTRL: s = SEL_SCTRL;
      ADDR_TCTRL: s = SEL_TCTRL;
      default:    s = SEL_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] ctrl_word(input logic rdy, input logic ovr);
    logic [31:0] w;
    w            = '0;
    w[READY_BIT] = rdy;
    w[OVR_BIT]   = ovr;
    return w;
  endfunction

endpackage

// File: rtl/mmio_io_responder_if.sv
// Data-memory bus between the MEM stage (master) and the I/O responder (slave).
// req_*  : one request per cycle, no back-pressure.
// resp_* : registered response, valid one cycle after the request.
interface mmio_io_responder_if #(
  parameter int DBITS = 32
);
  logic             req_valid;
  logic             req_we;
  logic [DBITS-1:0] req_addr;
  logic [DBITS-1:0] req_wdata;
  logic             resp_valid;
  logic             resp_hit;
  logic [DBITS-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  resp_valid, resp_hit, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output resp_valid, resp_hit, resp_rdata
  );
endinterface

// File: rtl/mmio_status_flag.sv
// Ready/Overrun status pair for one event source.
// Ports: clk, reset (sync, high); set = event this cycle; rd_clr = data
// register read (clears Ready); ovr_wr_clr = CTRL store with Overrun bit 0.
// rdy/ovr are the registered flags. A set always beats a same-cycle clear.
module mmio_status_flag (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic rd_clr,
  input  logic ovr_wr_clr,
  output logic rdy,
  output logic ovr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy <= 1'b0;
      ovr <= 1'b0;
    end else begin
      // Overrun means a second event arrived before Ready was consumed;
      // it looks at the pre-edge Ready.
      if (set && rdy)      ovr <= 1'b1;
      else if (ovr_wr_clr) ovr <= 1'b0;

      if (set)             rdy <= 1'b1;
      else if (rd_clr)     rdy <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_io_responder.sv
// Device side of the data-memory bus for the 0xF0000000 I/O window.
// Ports: clk, reset (sync, high); bus (slave modport: request in, response
// out one cycle later); key_n (raw active-low KEY pins); sw (switches);
// hex_out (four HEX nibbles); ledr_out (LED drive).
// Owns HEX/LEDR output registers, KEY/SW samplers with change flags and a
// millisecond timer with a limit register.
module mmio_io_responder
  import mmio_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int TICKS_PER_MS = 25000
) (
  input  logic                clk,
  input  logic                reset,
  mmio_io_responder_if.slave  bus,
  input  logic [3:0]          key_n,
  input  logic [9:0]          sw,
  output logic [15:0]         hex_out,
  output logic [9:0]          ledr_out
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  reg_sel_e         sel;
  logic             wr, rd, hit;
  logic [DBITS-1:0] rdata;

  logic [3:0]       key_smp;
  logic [9:0]       sw_smp;
  logic             key_chg, sw_chg;

  logic [PW-1:0]    presc;
  logic [DBITS-1:0] tcnt, tlim;
  logic             tick, wrap, tcnt_wr, tlim_wr, tim_evt;

  logic [NUM_FLAGS-1:0] flag_set, flag_rd_clr, flag_ovr_clr, flag_rdy, flag_ovr;

  // ---------------- decode ----------------
  assign sel = bus.req_valid ? decode_addr(bus.req_addr[31:0]) : SEL_NONE;
  assign hit = (sel != SEL_NONE);
  assign wr  = bus.req_valid &&  bus.req_we;
  assign rd  = bus.req_valid && !bus.req_we;

  // Read mux sees pre-edge state, so a load racing an update returns the old value.
  always_comb begin
    rdata = '0;
    if (!bus.req_we) begin
      case (sel)
        SEL_HEX:   rdata = DBITS'(hex_out);
        SEL_LEDR:  rdata = DBITS'(ledr_out);
        SEL_KEY:   rdata = DBITS'(key_smp);
        SEL_SW:    rdata = DBITS'(sw_smp);
        SEL_TCNT:  rdata = tcnt;
        SEL_TLIM:  rdata = tlim;
        SEL_KCTRL: rdata = DBITS'(ctrl_word(flag_rdy[FLG_KEY], flag_ovr[FLG_KEY]));
        SEL_SCTRL: rdata = DBITS'(ctrl_word(flag_rdy[FLG_SW],  flag_ovr[FLG_SW]));
        SEL_TCTRL: rdata = DBITS'(ctrl_word(flag_rdy[FLG_TIM], flag_ovr[FLG_TIM]));
        default:   rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_hit   <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= bus.req_valid;
      bus.resp_hit   <= hit;
      bus.resp_rdata <= rdata;
    end
  end

  // ---------------- output registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_out  <= '0;
      ledr_out <= '0;
    end else begin
      if (wr && sel == SEL_HEX)  hex_out  <= bus.req_wdata[15:0];
      if (wr && sel == SEL_LEDR) ledr_out <= bus.req_wdata[9:0];
    end
  end

  // ---------------- input samplers ----------------
  // Sampled through reset as well, so the first post-reset compare is against
  // the live pin state and no spurious change is seen.
  always_ff @(posedge clk) begin
    key_smp <= ~key_n;
    sw_smp  <= sw;
  end

  assign key_chg = (~key_n != key_smp);
  assign sw_chg  = (sw != sw_smp);

  // ---------------- timer ----------------
  assign tick    = (presc == PW'(TICKS_PER_MS - 1));
  assign tcnt_wr = wr && sel == SEL_TCNT;
  assign tlim_wr = wr && sel == SEL_TLIM;
  assign wrap    = tick && (tlim != '0) && (tcnt == tlim - DBITS'(1));
  // A software write to TCNT/TLIM overrides the tick, including its event.
  assign tim_evt = wrap && !tcnt_wr && !tlim_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      tcnt  <= '0;
      tlim  <= '0;
    end else if (tlim_wr) begin
      tlim  <= bus.req_wdata;
      tcnt  <= '0;
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tcnt_wr)   tcnt <= bus.req_wdata;
      else if (wrap) tcnt <= '0;
      else if (tick) tcnt <= tcnt + DBITS'(1);
    end
  end

  // ---------------- status flags ----------------
  assign flag_set     = {tim_evt, sw_chg, key_chg};
  assign flag_rd_clr  = {rd && sel == SEL_TCNT, rd && sel == SEL_SW, rd && sel == SEL_KEY};
  assign flag_ovr_clr = {wr && sel == SEL_TCTRL && !bus.req_wdata[OVR_BIT],
                         wr && sel == SEL_SCTRL && !bus.req_wdata[OVR_BIT],
                         wr && sel == SEL_KCTRL && !bus.req_wdata[OVR_BIT]};

  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
    mmio_status_flag u_flag (
      .clk        (clk),
      .reset      (reset),
      .set        (flag_set[i]),
      .rd_clr     (flag_rd_clr[i]),
      .ovr_wr_clr (flag_ovr_clr[i]),
      .rdy        (flag_rdy[i]),
      .ovr        (flag_ovr[i])
    );
  end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Self-checking bench for mmio_io_responder: directed scenarios plus a
// randomized run, all checked against a behavioural register-map model.
module tb_mmio_io_responder;
  import mmio_pkg::*;

  localparam int TPM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [15:0] hex_out;
  logic [9:0]  ledr_out;

  mmio_io_responder_if #(.DBITS(32)) bus ();

  mmio_io_responder #(.DBITS(32), .TICKS_PER_MS(TPM)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .key_n    (key_n),
    .sw       (sw),
    .hex_out  (hex_out),
    .ledr_out (ledr_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit [15:0] m_hex;
  bit [9:0]  m_ledr;
  bit [3:0]  m_key;
  bit [9:0]  m_sw;
  bit        m_rdy [3];
  bit        m_ovr [3];
  bit [31:0] m_tcnt, m_tlim;
  int        m_presc;
  logic [31:0] last_rd;

  function automatic bit [31:0] m_read(input bit [31:0] a, output bit h);
    bit [31:0] r;
    h = 1'b1;
    case (a)
      ADDR_HEX:   r = {16'h0, m_hex};
      ADDR_LEDR:  r = {22'h0, m_ledr};
      ADDR_KEY:   r = {28'h0, m_key};
      ADDR_SW:    r = {22'h0, m_sw};
      ADDR_TCNT:  r = m_tcnt;
      ADDR_TLIM:  r = m_tlim;
      ADDR_KCTRL: r = {29'h0, m_ovr[0], 1'b0, m_rdy[0]};
      ADDR_SCTRL: r = {29'h0, m_ovr[1], 1'b0, m_rdy[1]};
      ADDR_TCTRL: r = {29'h0, m_ovr[2], 1'b0, m_rdy[2]};
      default: begin h = 1'b0; r = 32'h0; end
    endcase
    return r;
  endfunction

  // One bus cycle: drive request, advance the model, check after the edge.
  task automatic cyc(input bit v, input bit we, input bit [31:0] a, input bit [31:0] wd);
    bit        h, e_valid, e_hit, e_load, tick, wr, rd;
    bit [31:0] r, e_rdata;
    bit [2:0]  set, rclr, oclr;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    if (reset) begin
      m_hex = 0; m_ledr = 0; m_tcnt = 0; m_tlim = 0; m_presc = 0;
      for (int i = 0; i < 3; i++) begin m_rdy[i] = 0; m_ovr[i] = 0; end
      m_key = ~key_n; m_sw = sw;
      e_valid = 0; e_hit = 0; e_load = 1; e_rdata = 0;
    end else begin
      r       = m_read(a, h);
      e_valid = v;
      e_hit   = v && h;
      e_load  = v && !we;
      e_rdata = e_hit ? r : 32'h0;
      wr = v && we;
      rd = v && !we;
      set[0]  = (~key_n != m_key);
      set[1]  = (sw != m_sw);
      set[2]  = 0;
      rclr[0] = rd && a == ADDR_KEY;
      rclr[1] = rd && a == ADDR_SW;
      rclr[2] = rd && a == ADDR_TCNT;
      oclr[0] = wr && a == ADDR_KCTRL && !wd[2];
      oclr[1] = wr && a == ADDR_SCTRL && !wd[2];
      oclr[2] = wr && a == ADDR_TCTRL && !wd[2];
      tick = (m_presc == TPM - 1);
      if (wr && a == ADDR_TLIM) begin
        m_tlim = wd; m_tcnt = 0; m_presc = 0;
      end else begin
        m_presc = tick ? 0 : m_presc + 1;
        if (wr && a == ADDR_TCNT) m_tcnt = wd;
        else if (tick) begin
          if (m_tlim != 0 && m_tcnt == m_tlim - 1) begin m_tcnt = 0; set[2] = 1; end
          else m_tcnt = m_tcnt + 1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (set[i] && m_rdy[i]) m_ovr[i] = 1;
        else if (oclr[i])       m_ovr[i] = 0;
        if (set[i])             m_rdy[i] = 1;
        else if (rclr[i])       m_rdy[i] = 0;
      end
      if (wr && a == ADDR_HEX)  m_hex  = wd[15:0];
      if (wr && a == ADDR_LEDR) m_ledr = wd[9:0];
      m_key = ~key_n;
      m_sw  = sw;
    end
    @(posedge clk);
    #1;
    chk("resp_valid", {31'h0, bus.resp_valid}, {31'h0, e_valid});
    chk("resp_hit",   {31'h0, bus.resp_hit},   {31'h0, e_hit});
    if (e_load) chk("resp_rdata", bus.resp_rdata, e_rdata);
    chk("hex_out",  {16'h0, hex_out},  {16'h0, m_hex});
    chk("ledr_out", {22'h0, ledr_out}, {22'h0, m_ledr});
    last_rd = bus.resp_rdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 32'h0);
  endtask

  task automatic ld(input bit [31:0] a);
    cyc(1, 0, a, 32'h0);
  endtask

  bit [31:0] addrs [11];
  bit [31:0] tseq [4];

  initial begin
    addrs = '{ADDR_HEX, ADDR_LEDR, ADDR_KEY, ADDR_SW, ADDR_TCNT, ADDR_TLIM,
              ADDR_KCTRL, ADDR_SCTRL, ADDR_TCTRL, 32'hF000_0008, 32'h0000_1000};
    tseq  = '{32'd0, 32'd1, 32'd2, 32'd0};
    reset = 1'b1; key_n = 4'hF; sw = 10'h0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
    idle(2);
    chk("rst_hex", {16'h0, hex_out}, 32'h0);
    chk("rst_valid", {31'h0, bus.resp_valid}, 32'h0);
    reset = 1'b0;

    // HEX store/load
    cyc(1, 1, ADDR_HEX, 32'h0000_BEEF);
    chk("hex_beef", {16'h0, hex_out}, 32'h0000_BEEF);
    ld(ADDR_HEX);
    chk("hex_load", last_rd, 32'h0000_BEEF);

    // KEY change
    key_n = 4'b1110;
    idle(1);
    ld(ADDR_KCTRL); chk("kctrl_set", last_rd, 32'h1);
    ld(ADDR_KEY);   chk("key_data",  last_rd, 32'h1);
    ld(ADDR_KCTRL); chk("kctrl_clr", last_rd, 32'h0);

    // SW double toggle -> overrun
    sw = sw ^ 10'h008; idle(1);
    sw = sw ^ 10'h008; idle(1);
    ld(ADDR_SCTRL); chk("sctrl_ovr", last_rd, 32'h5);
    cyc(1, 1, ADDR_SCTRL, 32'h0);
    ld(ADDR_SCTRL); chk("sctrl_ovclr", last_rd, 32'h1);
    ld(ADDR_SW);
    ld(ADDR_SCTRL); chk("sctrl_rdclr", last_rd, 32'h0);

    // Timer with limit 3
    cyc(1, 1, ADDR_TLIM, 32'd3);
    for (int k = 0; k < 4; k++) begin
      idle(3);
      ld(ADDR_TCNT);
      chk("tcnt_seq", last_rd, tseq[k]);
    end
    idle(24);
    ld(ADDR_TCTRL); chk("tctrl_ovr", last_rd, 32'h5);

    // KEY load racing a key change: set wins
    key_n = 4'b1100;
    ld(ADDR_KEY);
    ld(ADDR_KCTRL); chk("kctrl_race", last_rd, 32'h1);

    // TCNT store on a tick cycle
    cyc(1, 1, ADDR_TLIM, 32'd0);
    idle(3);
    cyc(1, 1, ADDR_TCNT, 32'h10);
    ld(ADDR_TCNT); chk("tcnt_store_tick", last_rd, 32'h10);

    // Unmapped load
    ld(32'hF000_0008);
    chk("unmap_valid", {31'h0, bus.resp_valid}, 32'h1);
    chk("unmap_hit",   {31'h0, bus.resp_hit},   32'h0);
    chk("unmap_rdata", bus.resp_rdata,          32'h0);

    // Reset mid-sequence
    cyc(1, 1, ADDR_LEDR, 32'h3FF);
    reset = 1'b1;
    cyc(1, 1, ADDR_HEX, 32'h1234);
    chk("mid_rst_hex",   {16'h0, hex_out},  32'h0);
    chk("mid_rst_ledr",  {22'h0, ledr_out}, 32'h0);
    chk("mid_rst_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("mid_rst_rdata", bus.resp_rdata, 32'h0);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit [31:0] a, wd;
      int idx;
      if ($urandom_range(0, 9) == 0) key_n = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 9);
        sw[idx] = ~sw[idx];
      end
      reset = ($urandom_range(0, 199) == 0);
      a  = addrs[$urandom_range(0, 10)];
      wd = $urandom;
      if (a == ADDR_TLIM || a == ADDR_TCNT) wd = $urandom_range(0, 6);
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, wd);
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
